// File: rtl/rca_pkg.sv
// rca_pkg: shared constants and types for the nibble-serial ripple-carry adder
package rca_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/rca_seq_adder_add4_slice.sv
// add4_slice: combinational 4-bit ripple-carry slice with carry-into-MSB tap
module add4_slice
  import rca_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t s,
  output logic    cout,
  output logic    c3
);
  logic [NIBBLE_W:0] c;
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout = c[NIBBLE_W];
  assign c3   = c[NIBBLE_W-1];
endmodule

// File: rtl/rca_seq_adder.sv
// rca_seq_adder: WIDTH-bit adder computed one nibble per cycle, LSB first
// Optional signed overflow output enabled by defining RCA_SEQ_OVF_EN.
module rca_seq_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef RCA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = NIB > 1 ? $clog2(NIB) : 1;
  generate
    if (WIDTH < NIBBLE_W || WIDTH % NIBBLE_W != 0) begin : g_bad_width
      $error("rca_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate
  state_t              state;
  logic [WIDTH-1:0]    ra, rb;
  logic                carry;
  logic [CW-1:0]       cnt;
  nibble_t             s;
  logic                co, c3;
  logic [WIDTH+3:0]    sum_cat;
  logic                last;
  add4_slice u_slice (
    .a   (ra[NIBBLE_W-1:0]),
    .b   (rb[NIBBLE_W-1:0]),
    .cin (carry),
    .s   (s),
    .cout(co),
    .c3  (c3)
  );
  // New nibble enters at the top; after NIB steps the sum is fully aligned.
  assign sum_cat = {s, sum};
  assign last    = cnt == CW'(NIB - 1);
`ifndef RCA_SEQ_OVF_EN
  logic unused_c3;
  assign unused_c3 = c3;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      cnt       <= '0;
      ra        <= '0;
      rb        <= '0;
      carry     <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          ra       <= a;
          rb       <= b;
          carry    <= cin;
          cnt      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          ra    <= ra >> NIBBLE_W;
          rb    <= rb >> NIBBLE_W;
          sum   <= sum_cat[WIDTH+3:NIBBLE_W];
          carry <= co;
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout      <= co;
            out_valid <= 1'b1;
`ifdef RCA_SEQ_OVF_EN
            ovf       <= c3 ^ co;
`endif
            state     <= DONE;
          end
        end
        DONE: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
